// File: rtl/dcache_tag_array_responder.sv
// -----------------------------------------------------------------------------
// dcache_tag_array_responder
//
// Purpose:
//   Responder end of the DCache tag-access request path. It owns the tag/valid
//   directory of a small set-associative cache and does two jobs:
//     * It accepts refill and invalidate writes. Writes are always accepted.
//     * It answers arbitrated {way_en, addr} read requests. The response comes
//       one cycle after the request fires. It carries the per-way tags, the
//       per-way valid bits, and a hit vector masked by way_en.
//   Writes take priority over reads. A read is never accepted in a cycle that
//   carries a write, so the directory can be read and written without any
//   same-cycle bypass path.
//
// Ports:
//   clock                 sole clock.
//   reset                 asynchronous active-low reset (0 = in reset).
//   io_req_valid/ready    read request handshake.
//   io_req_bits_way_en    way mask applied to the hit vector.
//   io_req_bits_addr      read physical address.
//   io_wr_valid           tag write/invalidate strobe (always accepted).
//   io_wr_bits_way_en     ways to write.
//   io_wr_bits_addr       address giving the set index and the tag.
//   io_wr_bits_inv        1 = clear valid bits only, 0 = write tag and set valid.
//   io_resp_valid/ready   response handshake.
//   io_resp_bits_tags     way w tag at bits [w*TAG_W +: TAG_W].
//   io_resp_bits_valids   per-way valid bits of the addressed set.
//   io_resp_bits_hit_way  valid & way_en & tag-match, per way.
//   io_resp_bits_hit      OR of io_resp_bits_hit_way.
// -----------------------------------------------------------------------------
module dcache_tag_array_responder #(
    parameter int WAYS   = 8,
    parameter int SETS   = 16,
    parameter int ADDR_W = 36,
    parameter int OFF_W  = 6,
    parameter int IDX_W  = $clog2(SETS),
    parameter int TAG_W  = ADDR_W - OFF_W - IDX_W
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [WAYS-1:0]       io_req_bits_way_en,
    input  logic [ADDR_W-1:0]     io_req_bits_addr,

    input  logic                  io_wr_valid,
    input  logic [WAYS-1:0]       io_wr_bits_way_en,
    input  logic [ADDR_W-1:0]     io_wr_bits_addr,
    input  logic                  io_wr_bits_inv,

    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [WAYS*TAG_W-1:0] io_resp_bits_tags,
    output logic [WAYS-1:0]       io_resp_bits_valids,
    output logic [WAYS-1:0]       io_resp_bits_hit_way,
    output logic                  io_resp_bits_hit
);

    // ------------------------------------------------------------------
    // Directory storage. It is kept as packed vectors so that the whole
    // array clears in a single reset assignment.
    // ------------------------------------------------------------------
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_mem_r;
    logic [SETS-1:0][WAYS-1:0]            vld_mem_r;

    // Response register.
    logic                  resp_valid_r;
    logic [WAYS*TAG_W-1:0] resp_tags_r;
    logic [WAYS-1:0]       resp_valids_r;
    logic [WAYS-1:0]       resp_hit_way_r;
    logic                  resp_hit_r;

    // Address decode and handshake terms.
    logic [IDX_W-1:0]      rd_idx_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [TAG_W-1:0]      wr_tag_s;
    logic                  req_ready_s;
    logic                  req_fire_s;
    logic                  resp_fire_s;

    // Lookup results for the set addressed by the current request.
    logic [WAYS*TAG_W-1:0] rd_tags_s;
    logic [WAYS-1:0]       rd_valids_s;
    logic [WAYS-1:0]       rd_hit_way_s;

    // The line-offset bits play no part in tag lookup.
    logic                  unused_offset_s;

    assign rd_idx_s = io_req_bits_addr[OFF_W +: IDX_W];
    assign rd_tag_s = io_req_bits_addr[ADDR_W-1 -: TAG_W];
    assign wr_idx_s = io_wr_bits_addr[OFF_W +: IDX_W];
    assign wr_tag_s = io_wr_bits_addr[ADDR_W-1 -: TAG_W];

    assign unused_offset_s = ^{io_req_bits_addr[OFF_W-1:0], io_wr_bits_addr[OFF_W-1:0]};

    // Handshake terms. A write cycle blocks reads, and so does a response
    // that is still stalled downstream. Ready is forced low while reset is
    // held. It never looks at io_req_valid, so no combinational loop is
    // formed through the arbiter.
    always_comb begin
        req_ready_s = 1'b0;
        if (reset && !io_wr_valid && (!resp_valid_r || io_resp_ready)) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
        req_fire_s  = io_req_valid && req_ready_s;
        resp_fire_s = resp_valid_r && io_resp_ready;
    end

    // Read the addressed set and build the masked per-way hit vector.
    always_comb begin
        rd_tags_s    = {(WAYS*TAG_W){1'b0}};
        rd_hit_way_s = {WAYS{1'b0}};
        rd_valids_s  = vld_mem_r[rd_idx_s];
        for (int w = 0; w < WAYS; w++) begin
            rd_tags_s[w*TAG_W +: TAG_W] = tag_mem_r[rd_idx_s][w];
            if (vld_mem_r[rd_idx_s][w] && io_req_bits_way_en[w] &&
                (tag_mem_r[rd_idx_s][w] == rd_tag_s)) begin
                rd_hit_way_s[w] = 1'b1;
            end else begin
                rd_hit_way_s[w] = 1'b0;
            end
        end
    end

    // Directory update. Refill writes the tag and sets valid. Invalidate
    // clears valid only and leaves the tag unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_mem_r <= {(SETS*WAYS*TAG_W){1'b0}};
            vld_mem_r <= {(SETS*WAYS){1'b0}};
        end else if (io_wr_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (io_wr_bits_way_en[w]) begin
                    if (io_wr_bits_inv) begin
                        vld_mem_r[wr_idx_s][w] <= 1'b0;
                    end else begin
                        tag_mem_r[wr_idx_s][w] <= wr_tag_s;
                        vld_mem_r[wr_idx_s][w] <= 1'b1;
                    end
                end
            end
        end else begin
            tag_mem_r <= tag_mem_r;
            vld_mem_r <= vld_mem_r;
        end
    end

    // Response register. A new request overwrites it; this also covers a
    // response and a request firing in the same cycle, which gives one
    // response per cycle. A response that fires with no new request empties
    // the register. Otherwise the payload holds, so later writes cannot
    // disturb a response that is stalled downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_r   <= 1'b0;
            resp_tags_r    <= {(WAYS*TAG_W){1'b0}};
            resp_valids_r  <= {WAYS{1'b0}};
            resp_hit_way_r <= {WAYS{1'b0}};
            resp_hit_r     <= 1'b0;
        end else if (req_fire_s) begin
            resp_valid_r   <= 1'b1;
            resp_tags_r    <= rd_tags_s;
            resp_valids_r  <= rd_valids_s;
            resp_hit_way_r <= rd_hit_way_s;
            resp_hit_r     <= |rd_hit_way_s;
        end else if (resp_fire_s) begin
            resp_valid_r   <= 1'b0;
        end else begin
            resp_valid_r   <= resp_valid_r;
        end
    end

    assign io_req_ready         = req_ready_s;
    assign io_resp_valid        = resp_valid_r;
    assign io_resp_bits_tags    = resp_tags_r;
    assign io_resp_bits_valids  = resp_valids_r;
    assign io_resp_bits_hit_way = resp_hit_way_r;
    assign io_resp_bits_hit     = resp_hit_r;

endmodule

// File: tb/tb_dcache_tag_array_responder.sv
module tb_dcache_tag_array_responder;

    localparam int WAYS   = 8;
    localparam int SETS   = 16;
    localparam int ADDR_W = 36;
    localparam int TAG_W  = 26;

    logic                  clock;
    logic                  reset;
    logic                  io_req_valid;
    logic                  io_req_ready;
    logic [WAYS-1:0]       io_req_bits_way_en;
    logic [ADDR_W-1:0]     io_req_bits_addr;
    logic                  io_wr_valid;
    logic [WAYS-1:0]       io_wr_bits_way_en;
    logic [ADDR_W-1:0]     io_wr_bits_addr;
    logic                  io_wr_bits_inv;
    logic                  io_resp_valid;
    logic                  io_resp_ready;
    logic [WAYS*TAG_W-1:0] io_resp_bits_tags;
    logic [WAYS-1:0]       io_resp_bits_valids;
    logic [WAYS-1:0]       io_resp_bits_hit_way;
    logic                  io_resp_bits_hit;

    int checks;
    int failures;

    dcache_tag_array_responder dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_valid         (io_req_valid),
        .io_req_ready         (io_req_ready),
        .io_req_bits_way_en   (io_req_bits_way_en),
        .io_req_bits_addr     (io_req_bits_addr),
        .io_wr_valid          (io_wr_valid),
        .io_wr_bits_way_en    (io_wr_bits_way_en),
        .io_wr_bits_addr      (io_wr_bits_addr),
        .io_wr_bits_inv       (io_wr_bits_inv),
        .io_resp_valid        (io_resp_valid),
        .io_resp_ready        (io_resp_ready),
        .io_resp_bits_tags    (io_resp_bits_tags),
        .io_resp_bits_valids  (io_resp_bits_valids),
        .io_resp_bits_hit_way (io_resp_bits_hit_way),
        .io_resp_bits_hit     (io_resp_bits_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [25:0] t, input logic [3:0] i,
                                                  input logic [5:0] o);
        mk_addr = {t, i, o};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; io_req_valid = 1'b0; io_req_bits_way_en = 8'h00;
        io_req_bits_addr = 36'h0; io_wr_valid = 1'b0; io_wr_bits_way_en = 8'h00;
        io_wr_bits_addr = 36'h0; io_wr_bits_inv = 1'b0; io_resp_ready = 1'b1;
        step(); step();
        io_req_valid = 1'b1;
        #1;
        checks++;
        if (io_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", io_resp_valid); end
        checks++;
        if (io_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b exp=0", io_req_ready); end
        checks++;
        if (io_resp_bits_hit !== 1'b0 || io_resp_bits_hit_way !== 8'h00) begin
            failures++; $display("FAIL reset_hit got=%0b/%h exp=0/00", io_resp_bits_hit, io_resp_bits_hit_way);
        end
        io_req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_read_empty();
        io_req_valid = 1'b1; io_req_bits_addr = 36'h0_0000_1040; io_req_bits_way_en = 8'h01;
        #1;
        checks++;
        if (io_req_ready !== 1'b1) begin failures++; $display("FAIL empty_req_ready got=%0b exp=1", io_req_ready); end
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h00 || io_resp_bits_hit !== 1'b0) begin
            failures++; $display("FAIL empty_resp got v=%0b valids=%h hit=%0b exp v=1 valids=00 hit=0",
                                 io_resp_valid, io_resp_bits_valids, io_resp_bits_hit);
        end
        checks++;
        if (io_resp_bits_tags !== {(WAYS*TAG_W){1'b0}}) begin
            failures++; $display("FAIL empty_tags got=%h exp=0", io_resp_bits_tags);
        end
        step();
        checks++;
        if (io_resp_valid !== 1'b0) begin failures++; $display("FAIL empty_drain got=%0b exp=0", io_resp_valid); end
    endtask

    task automatic test_write_hit();
        io_wr_valid = 1'b1; io_wr_bits_addr = 36'h1_2345_6780; io_wr_bits_way_en = 8'h04; io_wr_bits_inv = 1'b0;
        step();
        io_wr_valid = 1'b0;
        io_req_valid = 1'b1; io_req_bits_addr = 36'h1_2345_6780; io_req_bits_way_en = 8'hFF;
        step();
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h04 || io_resp_bits_hit_way !== 8'h04 ||
            io_resp_bits_hit !== 1'b1) begin
            failures++; $display("FAIL wr_hit got v=%0b valids=%h hw=%h hit=%0b exp 1/04/04/1",
                                 io_resp_valid, io_resp_bits_valids, io_resp_bits_hit_way, io_resp_bits_hit);
        end
        checks++;
        if (io_resp_bits_tags[2*TAG_W +: TAG_W] !== 26'h048D159) begin
            failures++; $display("FAIL wr_hit_tag got=%h exp=048d159", io_resp_bits_tags[2*TAG_W +: TAG_W]);
        end
        io_req_bits_way_en = 8'h02;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h04 || io_resp_bits_hit_way !== 8'h00 ||
            io_resp_bits_hit !== 1'b0) begin
            failures++; $display("FAIL masked_miss got v=%0b valids=%h hw=%h hit=%0b exp 1/04/00/0",
                                 io_resp_valid, io_resp_bits_valids, io_resp_bits_hit_way, io_resp_bits_hit);
        end
        step();
    endtask

    task automatic test_write_priority();
        io_wr_valid = 1'b1; io_wr_bits_addr = mk_addr(26'h2ABCDEF, 4'd3, 6'h2A);
        io_wr_bits_way_en = 8'h10; io_wr_bits_inv = 1'b0;
        io_req_valid = 1'b1; io_req_bits_addr = mk_addr(26'h2ABCDEF, 4'd3, 6'h11); io_req_bits_way_en = 8'h10;
        #1;
        checks++;
        if (io_req_ready !== 1'b0) begin failures++; $display("FAIL prio_ready_wr got=%0b exp=0", io_req_ready); end
        step();
        io_wr_valid = 1'b0;
        #1;
        checks++;
        if (io_req_ready !== 1'b1 || io_resp_valid !== 1'b0) begin
            failures++; $display("FAIL prio_ready_after got rdy=%0b v=%0b exp 1/0", io_req_ready, io_resp_valid);
        end
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_hit_way !== 8'h10 || io_resp_bits_hit !== 1'b1 ||
            io_resp_bits_tags[4*TAG_W +: TAG_W] !== 26'h2ABCDEF) begin
            failures++; $display("FAIL prio_resp got v=%0b hw=%h hit=%0b tag=%h exp 1/10/1/2abcdef", io_resp_valid,
                                 io_resp_bits_hit_way, io_resp_bits_hit, io_resp_bits_tags[4*TAG_W +: TAG_W]);
        end
    endtask

    // Continues from the hit response left pending by test_write_priority.
    task automatic test_hold();
        io_resp_ready = 1'b0;
        io_wr_valid = 1'b1; io_wr_bits_addr = mk_addr(26'h2ABCDEF, 4'd3, 6'h00);
        io_wr_bits_way_en = 8'h10; io_wr_bits_inv = 1'b1;
        io_req_valid = 1'b1; io_req_bits_addr = mk_addr(26'h2ABCDEF, 4'd3, 6'h00); io_req_bits_way_en = 8'h10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (io_req_ready !== 1'b0) begin failures++; $display("FAIL hold_ready c=%0d got=%0b exp=0", c, io_req_ready); end
            step();
            io_wr_valid = 1'b0;
            checks++;
            if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h10 || io_resp_bits_hit_way !== 8'h10 ||
                io_resp_bits_hit !== 1'b1 || io_resp_bits_tags[4*TAG_W +: TAG_W] !== 26'h2ABCDEF) begin
                failures++; $display("FAIL hold_bits c=%0d got v=%0b valids=%h hw=%h hit=%0b exp 1/10/10/1", c,
                                     io_resp_valid, io_resp_bits_valids, io_resp_bits_hit_way, io_resp_bits_hit);
            end
        end
        io_resp_ready = 1'b1;
        #1;
        checks++;
        if (io_req_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%0b exp=1", io_req_ready); end
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h00 || io_resp_bits_hit !== 1'b0 ||
            io_resp_bits_tags[4*TAG_W +: TAG_W] !== 26'h2ABCDEF) begin
            failures++; $display("FAIL inv_read got v=%0b valids=%h hit=%0b tag=%h exp 1/00/0/2abcdef", io_resp_valid,
                                 io_resp_bits_valids, io_resp_bits_hit, io_resp_bits_tags[4*TAG_W +: TAG_W]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_v;
        logic [25:0] exp_t;
        // Set s gets way s%8 with tag 0x100+s.
        for (int s = 0; s < SETS; s++) begin
            io_wr_valid = 1'b1; io_wr_bits_inv = 1'b0;
            io_wr_bits_way_en = 8'h01 << (s % 8);
            io_wr_bits_addr = mk_addr(26'h100 + 26'(s), 4'(s), 6'h00);
            step();
        end
        io_wr_valid = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            io_req_valid = 1'b1; io_req_bits_way_en = 8'hFF;
            io_req_bits_addr = mk_addr(26'h100 + 26'(s), 4'(s), 6'h3F);
            #1;
            checks++;
            if (io_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready s=%0d got=%0b exp=1", s, io_req_ready); end
            step();
            // Set 14 also holds the earlier refill in way 2.
            exp_v = (8'h01 << (s % 8)) | ((s == 14) ? 8'h04 : 8'h00);
            exp_t = 26'h100 + 26'(s);
            checks++;
            if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== exp_v ||
                io_resp_bits_hit_way !== (8'h01 << (s % 8)) || io_resp_bits_hit !== 1'b1 ||
                io_resp_bits_tags[(s % 8)*TAG_W +: TAG_W] !== exp_t) begin
                failures++; $display("FAIL b2b_resp s=%0d got v=%0b valids=%h hw=%h hit=%0b tag=%h exp valids=%h tag=%h",
                                     s, io_resp_valid, io_resp_bits_valids, io_resp_bits_hit_way, io_resp_bits_hit,
                                     io_resp_bits_tags[(s % 8)*TAG_W +: TAG_W], exp_v, exp_t);
            end
        end
        io_req_valid = 1'b0;
        step();
        checks++;
        if (io_resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", io_resp_valid); end
    endtask

    task automatic test_reset_mid();
        io_resp_ready = 1'b0;
        io_req_valid = 1'b1; io_req_bits_way_en = 8'hFF; io_req_bits_addr = mk_addr(26'h105, 4'd5, 6'h00);
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h20) begin
            failures++; $display("FAIL mid_pre got v=%0b valids=%h exp 1/20", io_resp_valid, io_resp_bits_valids);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b0) begin
            failures++; $display("FAIL mid_async got v=%0b rdy=%0b exp 0/0", io_resp_valid, io_req_ready);
        end
        step(); step();
        reset = 1'b1;
        io_resp_ready = 1'b1;
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_valids !== 8'h00 || io_resp_bits_hit !== 1'b0 ||
            io_resp_bits_tags[5*TAG_W +: TAG_W] !== 26'h0) begin
            failures++; $display("FAIL mid_after got v=%0b valids=%h hit=%0b tag=%h exp 1/00/0/0", io_resp_valid,
                                 io_resp_bits_valids, io_resp_bits_hit, io_resp_bits_tags[5*TAG_W +: TAG_W]);
        end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_read_empty();
        test_write_hit();
        test_write_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
